ocm_param_fetch: RTL and testbench
==================================

OCM_PARAM_FETCH -- requirements
Module: ocm_param_fetch

Interface
REQ-001 SHALL have parameter DEPTH, default 4, giving the number of 32-bit words fetched per frame.
REQ-002 SHALL have parameter ADDR_W, default 2, giving the memory address width; DEPTH SHALL equal 2**ADDR_W.
REQ-003 SHALL have port clk, input, 1, the single clock for all logic.
REQ-004 SHALL have port reset_n, input, 1, a synchronous active-low reset.
REQ-005 SHALL have port start, input, 1, a request to fetch all DEPTH words.
REQ-006 SHALL have port wb_req, input, 1, a single-word write request.
REQ-007 SHALL have port wb_addr, input, ADDR_W, the write word address.
REQ-008 SHALL have port wb_data, input, 32, the write data.
REQ-009 SHALL have port wb_be, input, 4, the write byte enables.
REQ-010 SHALL have port wb_ready, output, 1, high when wb_req will be accepted.
REQ-011 SHALL have port busy, output, 1, high while a fetch or write is in progress.
REQ-012 SHALL have port done, output, 1, a one-cycle pulse when a fetch frame completes.
REQ-013 SHALL have port params, output, 32*DEPTH, where word k occupies bits [32k+31:32k].
REQ-014 SHALL have port params_valid, output, 1, set at the first done and cleared only by reset.
REQ-015 SHALL have port param_xor, output, 32, the checksum of the current params (see Configuration).
REQ-016 SHALL have the memory-side ports mem_address (ADDR_W), mem_byteenable (4), mem_chipselect (1), mem_write (1), mem_writedata (32) and mem_clken (1) as outputs, and mem_readdata (32) as an input.

Function
REQ-017 SHALL have the FSM states IDLE, WRITE, READ and DRAIN.
REQ-018 SHALL treat the memory as having read latency 1: an address presented in cycle N returns mem_readdata valid in cycle N+1.
REQ-019 SHALL, in IDLE with start=1 and wb_req=0, move to READ and issue addresses 0..DEPTH-1 on consecutive cycles, with mem_chipselect=1, mem_write=0 and mem_byteenable=4'hF.
REQ-020 SHALL capture mem_readdata into shadow word k in the cycle after address k is issued; the cycle after the READ state issues address DEPTH-1 is the DRAIN state, in which the last word is captured.
REQ-021 SHALL, at the end of DRAIN, copy all shadow words into params atomically, pulse done for one cycle, set params_valid, and return to IDLE; params SHALL never show a partially updated frame.
REQ-022 SHALL assert done exactly DEPTH+2 cycles after the edge that samples start (6 cycles at DEPTH=4).
REQ-023 SHALL, in IDLE with wb_req=1, move to WRITE for exactly one cycle with mem_chipselect=1, mem_write=1, mem_address=wb_addr, mem_writedata=wb_data and mem_byteenable=wb_be, and then return to IDLE.
REQ-024 SHALL drive wb_ready = (state==IDLE) and ignore wb_req when wb_ready=0, with no queuing.
REQ-025 SHALL, when start and wb_req are both 1 in IDLE, perform the WRITE first and hold the start as pending, so the fetch begins in the cycle after WRITE and returns the written data.
REQ-026 SHALL, when start=1 while not in IDLE, set a single pending flag; any number of such starts SHALL collapse into one fetch, which begins immediately on return to IDLE.
REQ-027 SHALL drive mem_chipselect=0 and mem_write=0 when idle, and SHALL drive mem_clken=1 at all times.
REQ-028 SHALL drive busy = (state!=IDLE) or (pending start).
REQ-029 SHALL make every output a registered output, except wb_ready and busy, which are decoded from registers.

Reset
REQ-030 SHALL, on any clk edge with reset_n=0, enter IDLE and clear the pending flag, the shadow words, params, param_xor, params_valid, done and all memory-side outputs except mem_clken, which SHALL be 1.
REQ-031 SHALL, when reset occurs mid-fetch, abort the frame with no done pulse and leave params at 0.

Configuration
REQ-032 SHALL, when macro OCM_FETCH_CKSUM_EN is defined, make param_xor the XOR of all DEPTH shadow words, registered in the same cycle as params.
REQ-033 SHALL, when OCM_FETCH_CKSUM_EN is not defined, tie param_xor to 32'h0 and implement no XOR logic.

Verification
REQ-034 SHALL verify basic fetch: memory preloaded with 11111111/22222222/33333333/44444444 and a 1-cycle start -> addresses 0,1,2,3 issued on consecutive cycles, done on cycle 6, params=44444444_33333333_22222222_11111111, params_valid=1.
REQ-035 SHALL verify write then fetch: wb_req with addr=2, data=A5A5A5A5, be=4'b0011, then start -> word 2 reads 3333A5A5.
REQ-036 SHALL verify simultaneous start and wb_req: 1 WRITE cycle followed by a READ frame, with done on cycle 7 and the written value reflected in params.
REQ-037 SHALL verify three start pulses during busy -> exactly 2 done pulses in total, and wb_ready=0 throughout both frames.
REQ-038 SHALL verify reset_n=0 at cycle 3 of a fetch -> no done pulse, params=0, params_valid=0, IDLE on the next cycle.
REQ-039 SHALL verify, with OCM_FETCH_CKSUM_EN defined and the data of REQ-034, param_xor=44444444; without the macro, param_xor=0.

Source files
------------

// File: rtl/ocm_param_fetch_if.sv
// Memory-side bus of ocm_param_fetch: single-port on-chip RAM with read latency 1.
interface ocm_param_fetch_if #(
   parameter int ADDR_W = 2
);
   logic [ADDR_W-1:0] mem_address;
   logic [3:0]        mem_byteenable;
   logic              mem_chipselect;
   logic              mem_write;
   logic [31:0]       mem_writedata;
   logic              mem_clken;
   logic [31:0]       mem_readdata;

   modport master (
      output mem_address, mem_byteenable, mem_chipselect, mem_write, mem_writedata, mem_clken,
      input  mem_readdata
   );

   modport slave (
      input  mem_address, mem_byteenable, mem_chipselect, mem_write, mem_writedata, mem_clken,
      output mem_readdata
   );
endinterface

// File: rtl/ocm_param_fetch.sv
// Fetches DEPTH parameter words from on-chip RAM into an atomically updated register bank.
// Optional checksum output enabled by defining OCM_FETCH_CKSUM_EN.
module ocm_param_fetch #(
   parameter int DEPTH  = 4,
   parameter int ADDR_W = 2   // DEPTH must equal 2**ADDR_W
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  start,
   input  logic                  wb_req,
   input  logic [ADDR_W-1:0]     wb_addr,
   input  logic [31:0]           wb_data,
   input  logic [3:0]            wb_be,
   output logic                  wb_ready,
   output logic                  busy,
   output logic                  done,
   output logic [32*DEPTH-1:0]   params,
   output logic                  params_valid,
   output logic [31:0]           param_xor,
   ocm_param_fetch_if.master     mem
);

   typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_t;

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

   state_t            state_q, state_d;
   logic              pending_q, pending_d;
   logic [ADDR_W-1:0] addr_d;
   logic [3:0]        be_d;
   logic              cs_d, we_d;
   logic [31:0]       wdata_d;

   // Marks the cycle in which mem_readdata holds the word for cap_idx_q.
   logic              cap_en_q;
   logic [ADDR_W-1:0] cap_idx_q;
   logic [31:0]       shadow_q [DEPTH];
   logic [31:0]       frame    [DEPTH];
   logic [32*DEPTH-1:0] frame_packed;

   assign wb_ready = (state_q == IDLE);
   assign busy     = (state_q != IDLE) || pending_q;

   // NOTE: every always_comb output gets a default first so no path leaves a latch.
   always_comb begin
      state_d   = state_q;
      pending_d = pending_q;
      addr_d    = mem.mem_address;
      be_d      = mem.mem_byteenable;
      cs_d      = 1'b0;
      we_d      = 1'b0;
      wdata_d   = mem.mem_writedata;
      case (state_q)
         IDLE: begin
            if (wb_req) begin
               state_d   = WRITE;
               pending_d = pending_q | start;
               cs_d      = 1'b1;
               we_d      = 1'b1;
               addr_d    = wb_addr;
               be_d      = wb_be;
               wdata_d   = wb_data;
            end else if (start || pending_q) begin
               state_d   = READ;
               pending_d = 1'b0;
               cs_d      = 1'b1;
               addr_d    = '0;
               be_d      = 4'hF;
            end
         end
         WRITE: begin
            // A start held across the write launches the fetch right after it.
            if (start || pending_q) begin
               state_d   = READ;
               pending_d = 1'b0;
               cs_d      = 1'b1;
               addr_d    = '0;
               be_d      = 4'hF;
            end else begin
               state_d   = IDLE;
            end
         end
         READ: begin
            pending_d = pending_q | start;
            if (mem.mem_address == LAST_ADDR) begin
               state_d = DRAIN;
            end else begin
               cs_d    = 1'b1;
               addr_d  = mem.mem_address + 1'b1;
               be_d    = 4'hF;
            end
         end
         DRAIN: begin
            pending_d = pending_q | start;
            state_d   = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // The last word arrives during DRAIN, so the committed frame bypasses it in.
   always_comb begin
      for (int k = 0; k < DEPTH; k++) begin
         frame[k] = shadow_q[k];
      end
      if (cap_en_q) begin
         frame[cap_idx_q] = mem.mem_readdata;
      end
      frame_packed = '0;
      for (int k = 0; k < DEPTH; k++) begin
         frame_packed[32*k +: 32] = frame[k];
      end
   end

`ifdef OCM_FETCH_CKSUM_EN
   logic [31:0] xor_d;

   always_comb begin
      xor_d = '0;
      for (int k = 0; k < DEPTH; k++) begin
         xor_d = xor_d ^ frame[k];
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         param_xor <= '0;
      end else if (state_q == DRAIN) begin
         param_xor <= xor_d;
      end
   end
`else
   assign param_xor = 32'h0;
`endif

   // NOTE: sequential state uses non-blocking assignments only, so every flop sees pre-edge values.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q            <= IDLE;
         pending_q          <= 1'b0;
         mem.mem_address    <= '0;
         mem.mem_byteenable <= '0;
         mem.mem_chipselect <= 1'b0;
         mem.mem_write      <= 1'b0;
         mem.mem_writedata  <= '0;
         mem.mem_clken      <= 1'b1;
         cap_en_q           <= 1'b0;
         cap_idx_q          <= '0;
         // NOTE: the shadow bank is small flop storage, so it is cleared by reset like any register.
         for (int k = 0; k < DEPTH; k++) begin
            shadow_q[k] <= '0;
         end
         params             <= '0;
         params_valid       <= 1'b0;
         done               <= 1'b0;
      end else begin
         state_q            <= state_d;
         pending_q          <= pending_d;
         mem.mem_address    <= addr_d;
         mem.mem_byteenable <= be_d;
         mem.mem_chipselect <= cs_d;
         mem.mem_write      <= we_d;
         mem.mem_writedata  <= wdata_d;
         mem.mem_clken      <= 1'b1;
         cap_en_q           <= (state_q == READ);
         cap_idx_q          <= mem.mem_address;
         if (cap_en_q) begin
            shadow_q[cap_idx_q] <= mem.mem_readdata;
         end
         done <= (state_q == DRAIN);
         if (state_q == DRAIN) begin
            params       <= frame_packed;
            params_valid <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_ocm_param_fetch.sv
// Self-checking bench for ocm_param_fetch: RAM model, array reference model, directed and random frames.
module tb_ocm_param_fetch;
   localparam int DEPTH  = 4;
   localparam int ADDR_W = 2;

   logic                clk = 1'b0;
   logic                reset_n = 1'b0;
   logic                start = 1'b0;
   logic                wb_req = 1'b0;
   logic [ADDR_W-1:0]   wb_addr = '0;
   logic [31:0]         wb_data = '0;
   logic [3:0]          wb_be = '0;
   logic                wb_ready, busy, done, params_valid;
   logic [32*DEPTH-1:0] params;
   logic [31:0]         param_xor;

   int checks = 0;
   int errors = 0;

   logic [31:0] ram     [DEPTH];
   logic [31:0] ref_mem [DEPTH];

   ocm_param_fetch_if #(.ADDR_W(ADDR_W)) mem_bus ();

   ocm_param_fetch #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .start        (start),
      .wb_req       (wb_req),
      .wb_addr      (wb_addr),
      .wb_data      (wb_data),
      .wb_be        (wb_be),
      .wb_ready     (wb_ready),
      .busy         (busy),
      .done         (done),
      .params       (params),
      .params_valid (params_valid),
      .param_xor    (param_xor),
      .mem          (mem_bus)
   );

   always #5 clk = ~clk;

   // Synchronous RAM, read latency 1, byte-enabled writes.
   always @(posedge clk) begin
      if (mem_bus.mem_chipselect && mem_bus.mem_clken) begin
         if (mem_bus.mem_write) begin
            for (int b = 0; b < 4; b++) begin
               if (mem_bus.mem_byteenable[b]) begin
                  ram[mem_bus.mem_address][8*b +: 8] <= mem_bus.mem_writedata[8*b +: 8];
               end
            end
         end else begin
            mem_bus.mem_readdata <= ram[mem_bus.mem_address];
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] be);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
      return r;
   endfunction

   function automatic logic [127:0] ref_params();
      logic [127:0] p;
      p = '0;
      for (int k = 0; k < DEPTH; k++) p[32*k +: 32] = ref_mem[k];
      return p;
   endfunction

   function automatic logic [31:0] ref_xor();
      logic [31:0] x;
      x = '0;
`ifdef OCM_FETCH_CKSUM_EN
      for (int k = 0; k < DEPTH; k++) x = x ^ ref_mem[k];
`endif
      return x;
   endfunction

   task automatic do_reset();
      reset_n = 1'b0;
      tick();
      tick();
      reset_n = 1'b1;
   endtask

   task automatic do_write(input logic [ADDR_W-1:0] a, input logic [31:0] d, input logic [3:0] be, input string tag);
      wb_req = 1'b1; wb_addr = a; wb_data = d; wb_be = be;
      tick();
      wb_req = 1'b0;
      check({tag, "_ready_w"}, 128'(wb_ready), 128'(0));
      check({tag, "_busy_w"}, 128'(busy), 128'(1));
      check({tag, "_cs_we"}, 128'({mem_bus.mem_chipselect, mem_bus.mem_write}), 128'(2'b11));
      check({tag, "_wbus"}, 128'({mem_bus.mem_address, mem_bus.mem_byteenable, mem_bus.mem_writedata}),
            128'({a, be, d}));
      ref_mem[a] = merge(ref_mem[a], d, be);
      tick();
      check({tag, "_ready_back"}, 128'(wb_ready), 128'(1));
   endtask

   // Launch one fetch (optionally with a simultaneous write) and watch a bounded window.
   task automatic run_frame(input bit with_wb, input logic [ADDR_W-1:0] a, input logic [31:0] d,
                            input logic [3:0] be, input string tag);
      int done_cyc, n_done, first_rd, n_rd, rd_bad;
      start = 1'b1;
      if (with_wb) begin
         wb_req = 1'b1; wb_addr = a; wb_data = d; wb_be = be;
         ref_mem[a] = merge(ref_mem[a], d, be);
      end
      tick();
      start = 1'b0; wb_req = 1'b0;
      done_cyc = 0; n_done = 0; first_rd = 0; n_rd = 0; rd_bad = 0;
      for (int c = 1; c <= 16; c++) begin
         if (done === 1'b1) begin
            n_done++;
            if (done_cyc == 0) done_cyc = c;
         end
         if (mem_bus.mem_chipselect === 1'b1 && mem_bus.mem_write === 1'b0) begin
            if (n_rd == 0) first_rd = c;
            if (mem_bus.mem_address !== n_rd[ADDR_W-1:0] || c != first_rd + n_rd ||
                mem_bus.mem_byteenable !== 4'hF) rd_bad++;
            n_rd++;
         end
         tick();
      end
      check({tag, "_done_cycle"}, 128'(done_cyc), 128'(DEPTH + 2 + int'(with_wb)));
      check({tag, "_done_count"}, 128'(n_done), 128'(1));
      check({tag, "_first_rd"}, 128'(first_rd), 128'(1 + int'(with_wb)));
      check({tag, "_n_rd"}, 128'(n_rd), 128'(DEPTH));
      check({tag, "_rd_order"}, 128'(rd_bad), 128'(0));
      check({tag, "_params"}, params, ref_params());
      check({tag, "_valid"}, 128'(params_valid), 128'(1));
      check({tag, "_xor"}, 128'(param_xor), 128'(ref_xor()));
      check({tag, "_idle"}, 128'({wb_ready, busy, mem_bus.mem_chipselect}), 128'(3'b100));
   endtask

   initial begin
      int n_done, d1, d2, ready_hi, busy_lo;
      for (int k = 0; k < DEPTH; k++) ref_mem[k] = '0;

      // Reset state
      do_reset();
      check("rst_params", params, 128'(0));
      check("rst_valid", 128'(params_valid), 128'(0));
      check("rst_done", 128'(done), 128'(0));
      check("rst_xor", 128'(param_xor), 128'(0));
      check("rst_ready_busy", 128'({wb_ready, busy}), 128'(2'b10));
      check("rst_mem_ctl", 128'({mem_bus.mem_chipselect, mem_bus.mem_write, mem_bus.mem_clken}), 128'(3'b001));

      // Basic fetch
      do_write(2'd0, 32'h11111111, 4'hF, "pre0");
      do_write(2'd1, 32'h22222222, 4'hF, "pre1");
      do_write(2'd2, 32'h33333333, 4'hF, "pre2");
      do_write(2'd3, 32'h44444444, 4'hF, "pre3");
      run_frame(1'b0, '0, '0, '0, "basic");
      check("basic_const", params, 128'h44444444_33333333_22222222_11111111);
`ifdef OCM_FETCH_CKSUM_EN
      check("basic_xor_const", 128'(param_xor), 128'(32'h44444444));
`else
      check("basic_xor_const", 128'(param_xor), 128'(0));
`endif

      // Partial write then fetch
      do_write(2'd2, 32'hA5A5A5A5, 4'b0011, "wr2");
      run_frame(1'b0, '0, '0, '0, "wr_fetch");
      check("wr_fetch_word2", 128'(params[95:64]), 128'(32'h3333A5A5));

      // Simultaneous start and write
      run_frame(1'b1, 2'd0, 32'hDEADBEEF, 4'b1100, "simul");
      check("simul_word0", 128'(params[31:0]), 128'(32'hDEAD1111));

      // Three extra starts while busy collapse into one more frame
      start = 1'b1;
      tick();
      start = 1'b0;
      n_done = 0; d1 = 0; d2 = 0; ready_hi = 0; busy_lo = 0;
      for (int c = 1; c <= 20; c++) begin
         if (done === 1'b1) begin
            n_done++;
            if (d1 == 0) d1 = c; else if (d2 == 0) d2 = c;
         end
         if (c <= 11 && wb_ready !== 1'b0) ready_hi++;
         if (c <= 11 && busy !== 1'b1) busy_lo++;
         start = (c == 2 || c == 4 || c == 6);
         tick();
      end
      start = 1'b0;
      check("multi_done_count", 128'(n_done), 128'(2));
      check("multi_done1", 128'(d1), 128'(DEPTH + 2));
      check("multi_done2", 128'(d2), 128'(2*DEPTH + 4));
      check("multi_ready_gap_only", 128'(ready_hi), 128'(1));
      check("multi_busy", 128'(busy_lo), 128'(0));
      check("multi_params", params, ref_params());

      // Random frames
      for (int it = 0; it < 5; it++) begin
         logic [31:0] rd;
         logic [ADDR_W-1:0] ra;
         for (int k = 0; k < DEPTH; k++) do_write(ADDR_W'(k), $urandom, 4'hF, $sformatf("rnd%0d_pre%0d", it, k));
         for (int w = 0; w < int'($urandom_range(2, 0)); w++) begin
            ra = ADDR_W'($urandom_range(DEPTH - 1, 0));
            rd = $urandom;
            do_write(ra, rd, 4'($urandom_range(15, 0)), $sformatf("rnd%0d_wr%0d", it, w));
         end
         ra = ADDR_W'($urandom_range(DEPTH - 1, 0));
         run_frame(1'($urandom_range(1, 0)), ra, $urandom, 4'($urandom_range(15, 0)), $sformatf("rnd%0d", it));
      end

      // Reset in the middle of a fetch
      do_reset();
      check("abort_pre_params", params, 128'(0));
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      reset_n = 1'b0;
      tick();
      check("abort_idle", 128'({wb_ready, busy, mem_bus.mem_chipselect}), 128'(3'b100));
      reset_n = 1'b1;
      n_done = 0;
      for (int c = 0; c < 10; c++) begin
         if (done === 1'b1) n_done++;
         tick();
      end
      check("abort_no_done", 128'(n_done), 128'(0));
      check("abort_params", params, 128'(0));
      check("abort_valid", 128'(params_valid), 128'(0));
      check("abort_xor", 128'(param_xor), 128'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
